atm_request_sequencer: RTL and testbench

- Customer-side front end that drives the ATM transaction core: collects keypad entries and the biometric result, then presents one fully formed request.
- Request fields: PIN, amount, biometric flag, change-PIN, new PIN, inactivity timeout.
- After presenting, waits a fixed latency, samples the core's registered status flags and reports one result per session.
- Sits between the keypad/biometric scanner and the core; it is the initiator end of the core's request interface.

---
 rtl/atm_pkg.sv | 31 +++
 rtl/atm_inactivity_timer.sv | 25 ++
 rtl/atm_request_sequencer.sv | 178 +++++++++++++++++
 tb/tb_atm_request_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and encodings for the ATM request sequencer.
package atm_pkg;

  typedef enum logic [3:0] {
    IDLE, GET_PIN, GET_BIO, MENU, GET_AMT, GET_NEWPIN, PRESENT, WAIT, REPORT
  } atm_seq_state_t;

  localparam logic [1:0] KEY_DIGIT  = 2'd0;
  localparam logic [1:0] KEY_ENTER  = 2'd1;
  localparam logic [1:0] KEY_CANCEL = 2'd2;
  localparam logic [1:0] KEY_CHG    = 2'd3;

  localparam logic [7:0] AMOUNT_SAT = 8'd255;

  typedef struct packed {
    logic [3:0] pin;
    logic [7:0] amount;
    logic       bio;
    logic       chg;
    logic [3:0] new_pin;
    logic       tmo;
  } atm_req_t;

  // Decimal shift-in with saturation; 255*10+15 still fits in 12 bits.
  function automatic logic [7:0] amt_accum(input logic [7:0] amt, input logic [3:0] dig);
    logic [11:0] sum;
    sum = 12'(amt) * 12'd10 + 12'(dig);
    return (sum > 12'(AMOUNT_SAT)) ? AMOUNT_SAT : sum[7:0];
  endfunction

endpackage

// File: rtl/atm_inactivity_timer.sv
// Idle-cycle counter: any customer event clears it, it counts while enabled,
// and expire fires on the cycle the count sits at CYCLES-1 with no event.
module atm_inactivity_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + W'(1);
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/atm_request_sequencer.sv
// Keypad/biometric front end that builds one request for the ATM core and
// reports one result per session. Define ATM_SEQ_STATS_EN for sess_count.
module atm_request_sequencer
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES    = 1000,
  parameter int unsigned RESP_WAIT         = 1,
  parameter int unsigned MAX_AMOUNT_DIGITS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [1:0] key_cmd,
  input  logic [3:0] key_digit,
  input  logic       bio_done,
  input  logic       bio_match,
  input  logic       core_tx_success,
  input  logic       core_tx_error,
  input  logic       core_pin_chg_ok,
  input  logic       core_locked,
  input  logic       core_timeout,
  output logic       present,
  output logic [3:0] pin_input,
  output logic [7:0] amount_input,
  output logic       biometric_authenticated,
  output logic       change_pin_request,
  output logic [3:0] new_pin,
  output logic       inactivity_timeout,
  output logic       result_valid,
  output logic       result_ok,
  output logic       result_locked,
  output logic       busy
`ifdef ATM_SEQ_STATS_EN
  ,
  output logic [15:0] sess_count
`endif
);
  localparam int unsigned   DW        = $clog2(MAX_AMOUNT_DIGITS + 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(MAX_AMOUNT_DIGITS);
  localparam logic [2:0]    WAIT_LAST = 3'(RESP_WAIT - 1);

  atm_seq_state_t state;
  atm_req_t       req;
  logic [DW-1:0]  amt_dig;
  logic [2:0]     wcnt;
  logic           pin_seen;
  logic           in_entry, expire, core_to_unused;
  logic           k_digit, k_enter, k_cancel, k_chg, dec_digit;

  assign k_digit   = key_valid && (key_cmd == KEY_DIGIT);
  assign k_enter   = key_valid && (key_cmd == KEY_ENTER);
  assign k_cancel  = key_valid && (key_cmd == KEY_CANCEL);
  assign k_chg     = key_valid && (key_cmd == KEY_CHG);
  assign dec_digit = (key_digit <= 4'd9);
  assign in_entry  = state inside {GET_PIN, GET_BIO, MENU, GET_AMT, GET_NEWPIN};
  // The core's own timeout flag does not feed the session result.
  assign core_to_unused = core_timeout;

  atm_inactivity_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (key_valid | bio_done),
    .en      (in_entry),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req           <= '0;
      amt_dig       <= '0;
      wcnt          <= '0;
      pin_seen      <= 1'b0;
      present       <= 1'b0;
      result_valid  <= 1'b0;
      result_ok     <= 1'b0;
      result_locked <= 1'b0;
    end else begin
      present      <= 1'b0;
      result_valid <= 1'b0;
      // Cancel beats everything, including a same-cycle bio_done.
      if (in_entry && k_cancel) begin
        state         <= REPORT;
        result_valid  <= 1'b1;
        result_ok     <= 1'b0;
        result_locked <= 1'b0;
      end else if (expire) begin
        req.tmo <= 1'b1;
        present <= 1'b1;
        state   <= PRESENT;
      end else begin
        case (state)
          IDLE: if (key_valid) state <= GET_PIN;
          GET_PIN: begin
            if (k_digit) begin
              req.pin  <= key_digit;
              pin_seen <= 1'b1;
            end else if (k_enter && pin_seen) begin
              state <= GET_BIO;
            end
          end
          GET_BIO: if (bio_done) begin
            req.bio <= bio_match;
            state   <= MENU;
          end
          MENU: begin
            if (k_chg) begin
              state <= GET_NEWPIN;
            end else if (k_digit && dec_digit) begin
              req.amount <= {4'd0, key_digit};
              amt_dig    <= DW'(1);
              state      <= GET_AMT;
            end
          end
          GET_AMT: begin
            if (k_digit && dec_digit && amt_dig < DIG_MAX) begin
              req.amount <= amt_accum(req.amount, key_digit);
              amt_dig    <= amt_dig + DW'(1);
            end else if (k_enter) begin
              present <= 1'b1;
              state   <= PRESENT;
            end
          end
          GET_NEWPIN: begin
            if (k_digit) begin
              req.new_pin <= key_digit;
            end else if (k_enter) begin
              req.chg <= 1'b1;
              present <= 1'b1;
              state   <= PRESENT;
            end
          end
          PRESENT: begin
            wcnt  <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (wcnt == WAIT_LAST) begin
              result_valid  <= 1'b1;
              result_ok     <= req.tmo ? 1'b0 :
                               req.chg ? core_pin_chg_ok :
                                         (core_tx_success & ~core_tx_error);
              result_locked <= core_locked;
              state         <= REPORT;
            end else begin
              wcnt <= wcnt + 3'd1;
            end
          end
          REPORT: begin
            req           <= '0;
            amt_dig       <= '0;
            pin_seen      <= 1'b0;
            result_ok     <= 1'b0;
            result_locked <= 1'b0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ATM_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        sess_count <= '0;
    else if (state == REPORT && result_ok) sess_count <= sess_count + 16'd1;
  end
`endif

  assign pin_input               = req.pin;
  assign amount_input            = req.amount;
  assign biometric_authenticated = req.bio;
  assign change_pin_request      = req.chg;
  assign new_pin                 = req.new_pin;
  assign inactivity_timeout      = req.tmo;
  assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_atm_request_sequencer.sv
// Session-level bench: table rows, directed corner sequences, random sessions.
module tb_atm_request_sequencer;
  localparam int TO = 40;
  localparam int RW = 2;
  localparam logic [1:0] KD = 2'd0, KE = 2'd1, KC = 2'd2, KX = 2'd3;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       key_valid = 1'b0, bio_done = 1'b0, bio_match = 1'b0;
  logic [1:0] key_cmd = '0;
  logic [3:0] key_digit = '0;
  logic       core_tx_success = 1'b0, core_tx_error = 1'b0, core_pin_chg_ok = 1'b0;
  logic       core_locked = 1'b0, core_timeout = 1'b0;
  logic       present, biometric_authenticated, change_pin_request, inactivity_timeout;
  logic       result_valid, result_ok, result_locked, busy;
  logic [3:0] pin_input, new_pin;
  logic [7:0] amount_input;

  always #5 clk = ~clk;

  atm_request_sequencer #(.TIMEOUT_CYCLES(TO), .RESP_WAIT(RW), .MAX_AMOUNT_DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_cmd(key_cmd),
    .key_digit(key_digit), .bio_done(bio_done), .bio_match(bio_match),
    .core_tx_success(core_tx_success), .core_tx_error(core_tx_error),
    .core_pin_chg_ok(core_pin_chg_ok), .core_locked(core_locked),
    .core_timeout(core_timeout), .present(present), .pin_input(pin_input),
    .amount_input(amount_input), .biometric_authenticated(biometric_authenticated),
    .change_pin_request(change_pin_request), .new_pin(new_pin),
    .inactivity_timeout(inactivity_timeout), .result_valid(result_valid),
    .result_ok(result_ok), .result_locked(result_locked), .busy(busy)
  );

  typedef struct packed {
    int cyc; int idle;
    logic [3:0] pin; logic [7:0] amt; logic bio; logic chg; logic [3:0] np; logic tmo;
  } pres_t;
  typedef struct packed { int cyc; logic ok; logic lk; } res_t;
  typedef struct packed {
    logic pres; logic [3:0] pin; logic [7:0] amt; logic bio; logic chg;
    logic [3:0] np; logic tmo; logic ok; logic lk;
  } exp_t;
  typedef struct packed {
    logic [3:0] pin; logic bm; logic chg; logic [2:0] nd; logic [0:4][3:0] d;
    logic [3:0] fl; logic [7:0] e_amt; logic [3:0] e_np; logic e_ok; logic e_lk;
  } vec_t;

  pres_t pq[$];
  res_t  rq[$];
  pres_t mp;
  res_t  mr;
  int    cyc = 0, last_evt = 0;
  int    n_chk = 0, n_pass = 0;
  vec_t  tbl[0:6];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset_n) begin
      if (present) begin
        mp.cyc = cyc; mp.idle = cyc - last_evt; mp.pin = pin_input; mp.amt = amount_input;
        mp.bio = biometric_authenticated; mp.chg = change_pin_request;
        mp.np = new_pin; mp.tmo = inactivity_timeout;
        pq.push_back(mp);
      end
      if (result_valid) begin
        mr.cyc = cyc; mr.ok = result_ok; mr.lk = result_locked;
        rq.push_back(mr);
      end
      if (key_valid || bio_done) last_evt = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int g();
    return int'($urandom_range(0, 4));
  endfunction

  task automatic key(input logic [1:0] c, input logic [3:0] d, input int gap);
    key_valid = 1'b1; key_cmd = c; key_digit = d;
    tick(1);
    key_valid = 1'b0; key_cmd = '0; key_digit = '0;
    tick(gap);
  endtask

  task automatic bio(input logic m, input int gap);
    bio_done = 1'b1; bio_match = m;
    tick(1);
    bio_done = 1'b0; bio_match = 1'b0;
    tick(gap);
  endtask

  task automatic set_core(input logic [3:0] fl);
    {core_tx_success, core_tx_error, core_pin_chg_ok, core_locked} = fl;
  endtask

  task automatic check_session(input string nm, input exp_t e);
    int t = 0;
    while (rq.size() == 0 && t < 200) begin tick(1); t++; end
    if (rq.size() == 0) begin
      chk({nm, "_result_seen"}, 32'(rq.size()), 32'd1);
      return;
    end
    tick(2);
    chk({nm, "_present_cnt"}, 32'(pq.size()), 32'(e.pres));
    chk({nm, "_result_cnt"}, 32'(rq.size()), 32'd1);
    chk({nm, "_ok"}, 32'(rq[0].ok), 32'(e.ok));
    chk({nm, "_locked"}, 32'(rq[0].lk), 32'(e.lk));
    if (e.pres && pq.size() == 1) begin
      chk({nm, "_pin"}, 32'(pq[0].pin), 32'(e.pin));
      chk({nm, "_amount"}, 32'(pq[0].amt), 32'(e.amt));
      chk({nm, "_bio"}, 32'(pq[0].bio), 32'(e.bio));
      chk({nm, "_chg"}, 32'(pq[0].chg), 32'(e.chg));
      chk({nm, "_newpin"}, 32'(pq[0].np), 32'(e.np));
      chk({nm, "_tmo"}, 32'(pq[0].tmo), 32'(e.tmo));
      chk({nm, "_latency"}, 32'(rq[0].cyc - pq[0].cyc), 32'(RW + 1));
    end
    chk({nm, "_idle_after"}, 32'({busy, pin_input, amount_input, new_pin,
        biometric_authenticated, change_pin_request, inactivity_timeout}), 32'd0);
  endtask

  function automatic vec_t row(input logic [3:0] pin, input logic bm, input logic chg,
                               input int nd, input logic [19:0] d, input logic [3:0] fl,
                               input logic [7:0] ea, input logic [3:0] en,
                               input logic eo, input logic el);
    vec_t v;
    v.pin = pin; v.bm = bm; v.chg = chg; v.nd = 3'(nd); v.d = d; v.fl = fl;
    v.e_amt = ea; v.e_np = en; v.e_ok = eo; v.e_lk = el;
    return v;
  endfunction

  task automatic run_row(input vec_t v, input int id);
    exp_t e;
    pq.delete(); rq.delete();
    set_core(v.fl);
    key(KD, 4'd9, 1);
    key(KD, v.pin, 1);
    key(KE, 4'd0, 1);
    bio(v.bm, 1);
    if (v.chg) key(KX, 4'd0, 1);
    for (int i = 0; i < int'(v.nd); i++) key(KD, v.d[i], 1);
    key(KE, 4'd0, 0);
    e = '0;
    e.pres = 1'b1; e.pin = v.pin; e.amt = v.e_amt; e.bio = v.bm; e.chg = v.chg;
    e.np = v.e_np; e.ok = v.e_ok; e.lk = v.e_lk;
    check_session($sformatf("vec%0d", id), e);
  endtask

  task automatic rand_session(input int id);
    exp_t e;
    int mode, cp, n, cnt, a, c;
    logic [3:0] d, fl;
    logic chgp;
    string nm;
    nm = $sformatf("rnd%0d", id);
    e = '0; pq.delete(); rq.delete();
    fl = 4'($urandom); set_core(fl);
    mode = int'($urandom_range(0, 9));
    cp = (mode < 2) ? int'($urandom_range(1, 4)) : 0;
    key(KD, 4'($urandom), g());
    if ($urandom_range(0, 2) == 0) key(KE, 4'd0, g());
    n = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++) begin d = 4'($urandom); e.pin = d; key(KD, d, g()); end
    if (cp == 1) begin e = '0; key(KC, 4'd0, 0); check_session(nm, e); return; end
    key(KE, 4'd0, g());
    if ($urandom_range(0, 1) == 1) begin
      c = int'($urandom_range(0, 2));
      key((c == 2) ? KX : 2'(c), 4'($urandom), g());
    end
    if (cp == 2) begin
      e = '0;
      if ($urandom_range(0, 1) == 1) begin bio_done = 1'b1; bio_match = 1'b1; end
      key(KC, 4'd0, 0);
      bio_done = 1'b0; bio_match = 1'b0;
      check_session(nm, e);
      return;
    end
    e.bio = 1'($urandom); bio(e.bio, g());
    if (cp == 3) begin e = '0; key(KC, 4'd0, 0); check_session(nm, e); return; end
    chgp = 1'($urandom);
    if (chgp) begin
      key(KX, 4'd0, g());
      n = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin d = 4'($urandom); e.np = d; key(KD, d, g()); end
    end else begin
      d = 4'($urandom_range(0, 9)); e.amt = {4'd0, d}; cnt = 1; key(KD, d, g());
      n = int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) begin
        d = 4'($urandom);
        if (d <= 4'd9 && cnt < 3) begin
          a = int'(e.amt) * 10 + int'(d);
          e.amt = (a > 255) ? 8'd255 : 8'(a);
          cnt++;
        end
        key(KD, d, g());
      end
    end
    if (cp == 4) begin e = '0; key(KC, 4'd0, 0); check_session(nm, e); return; end
    e.pres = 1'b1; e.lk = fl[0];
    if (mode == 2) begin
      e.tmo = 1'b1; e.ok = 1'b0;
      check_session({nm, "_tmo"}, e);
      if (pq.size() == 1) chk({nm, "_tmo_idle"}, 32'(pq[0].idle), 32'(TO + 1));
      return;
    end
    key(KE, 4'd0, 0);
    e.chg = chgp;
    e.ok  = chgp ? fl[1] : (fl[3] & ~fl[2]);
    check_session(nm, e);
  endtask

  initial begin
    exp_t e;
    tbl[0] = row(4'd10, 1'b1, 1'b0, 2, {4'd5, 4'd0, 4'd0, 4'd0, 4'd0}, 4'b1000, 8'd50, 4'd0, 1'b1, 1'b0);
    tbl[1] = row(4'd3, 1'b0, 1'b0, 4, {4'd9, 4'd9, 4'd9, 4'd9, 4'd0}, 4'b1000, 8'd255, 4'd0, 1'b1, 1'b0);
    tbl[2] = row(4'd10, 1'b1, 1'b1, 1, {4'd3, 4'd0, 4'd0, 4'd0, 4'd0}, 4'b0010, 8'd0, 4'd3, 1'b1, 1'b0);
    tbl[3] = row(4'd7, 1'b1, 1'b1, 2, {4'd8, 4'd6, 4'd0, 4'd0, 4'd0}, 4'b1001, 8'd0, 4'd6, 1'b0, 1'b1);
    tbl[4] = row(4'd1, 1'b0, 1'b0, 3, {4'd2, 4'd5, 4'd6, 4'd0, 4'd0}, 4'b1100, 8'd255, 4'd0, 1'b0, 1'b0);
    tbl[5] = row(4'd4, 1'b1, 1'b0, 3, {4'd4, 4'd15, 4'd2, 4'd0, 4'd0}, 4'b1000, 8'd42, 4'd0, 1'b1, 1'b0);
    tbl[6] = row(4'd0, 1'b0, 1'b0, 1, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 4'b1010, 8'd0, 4'd0, 1'b1, 1'b0);

    #2;
    chk("reset_outputs", 32'({present, pin_input, amount_input, biometric_authenticated,
        change_pin_request, new_pin, inactivity_timeout, result_valid, result_ok,
        result_locked, busy}), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("idle_after_release", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) run_row(tbl[i], i);

    // Enter with no PIN digit is ignored, and so is a bio event in GET_PIN.
    pq.delete(); rq.delete(); set_core(4'b1000);
    key(KD, 4'd9, 1); key(KE, 4'd0, 1); bio(1'b1, 1);
    key(KD, 4'd5, 1); key(KE, 4'd0, 1); bio(1'b0, 1);
    key(KD, 4'd1, 1); key(KE, 4'd0, 0);
    e = '0; e.pres = 1'b1; e.pin = 4'd5; e.amt = 8'd1; e.ok = 1'b1;
    check_session("empty_enter", e);

    // Stall in GET_AMT until the inactivity timer fires.
    pq.delete(); rq.delete(); set_core(4'b1000);
    key(KD, 4'd9, 1); key(KD, 4'd2, 1); key(KE, 4'd0, 1); bio(1'b1, 1);
    key(KD, 4'd7, 0);
    e = '0; e.pres = 1'b1; e.pin = 4'd2; e.amt = 8'd7; e.bio = 1'b1; e.tmo = 1'b1;
    check_session("timeout", e);
    if (pq.size() == 1) chk("timeout_idle_cycles", 32'(pq[0].idle), 32'(TO + 1));

    // Cancel and bio_done together: cancel wins.
    pq.delete(); rq.delete(); set_core(4'b1010);
    key(KD, 4'd9, 1); key(KD, 4'd3, 1); key(KE, 4'd0, 1);
    bio_done = 1'b1; bio_match = 1'b1;
    key(KC, 4'd0, 0);
    bio_done = 1'b0; bio_match = 1'b0;
    e = '0;
    check_session("cancel_bio", e);

    // A key arriving during WAIT is dropped and must not start a session.
    pq.delete(); rq.delete(); set_core(4'b1000);
    key(KD, 4'd9, 1); key(KD, 4'd6, 1); key(KE, 4'd0, 1); bio(1'b0, 1);
    key(KD, 4'd8, 1); key(KE, 4'd0, 0);
    tick(1);
    key(KD, 4'd1, 0);
    e = '0; e.pres = 1'b1; e.pin = 4'd6; e.amt = 8'd8; e.ok = 1'b1;
    check_session("key_in_wait", e);

    // Reset in WAIT: outputs drop at once, no late result after release.
    pq.delete(); rq.delete(); set_core(4'b1000);
    key(KD, 4'd9, 1); key(KD, 4'd6, 1); key(KE, 4'd0, 1); bio(1'b1, 1);
    key(KD, 4'd4, 1); key(KE, 4'd0, 0);
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("reset_in_wait_outputs", 32'({present, pin_input, amount_input, biometric_authenticated,
        change_pin_request, new_pin, inactivity_timeout, result_valid, result_ok,
        result_locked, busy}), 32'd0);
    tick(1);
    reset_n = 1'b1;
    pq.delete(); rq.delete();
    tick(10);
    chk("reset_in_wait_no_result", 32'(rq.size()), 32'd0);
    chk("reset_in_wait_idle", 32'(busy), 32'd0);

    for (int s = 0; s < 40; s++) rand_session(s);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
